// File: rtl/spi_xfer_arbiter.sv
// Round-robin SPI transaction controller sharing one byte engine between two requesters.
// Optional per-byte watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned GAP_CYC     = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] gnt,
  output logic       tx_ack,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       err,
  output logic       eng_start,
  output logic [7:0] eng_tx,
  input  logic       eng_busy,
  input  logic       eng_done,
  input  logic [7:0] eng_rx,
  output logic       ss_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_GAP,
    ST_HOLD
  } state_e;

  localparam logic [3:0] SETUP_M1 = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HOLD_N   = 4'(HOLD_CYC);
  localparam logic [3:0] GAP_N    = 4'(GAP_CYC);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || HOLD_CYC < 1 || HOLD_CYC > 15 ||
      GAP_CYC > 15 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("spi_xfer_arbiter: parameter out of range");
  end

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       ss_n_q, ss_n_d;
  logic       tx_ack_q, tx_ack_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic       eng_start_q, eng_start_d;
  logic [7:0] eng_tx_q, eng_tx_d;
  logic       win1;
  logic [7:0] sel_tx;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    pcnt_d      = pcnt_q;
    ss_n_d      = ss_n_q;
    rx_data_d   = rx_data_q;
    eng_tx_d    = eng_tx_q;
    tx_ack_d    = 1'b0;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    eng_start_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = 1'b0;
`endif
    win1   = (req == 2'b11) ? ~last_q : req[1];
    sel_tx = gnt_q[1] ? tx_data1 : tx_data0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (req == 2'b00) begin
          state_d = ST_IDLE;
        end else begin
          gnt_d   = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          bcnt_d  = win1 ? len1 : len0;
          ss_n_d  = 1'b0;
          // LOAD supplies the last setup cycle, since eng_start is registered out of it
          pcnt_d  = SETUP_M1;
          state_d = (SETUP_M1 == 4'd0) ? ST_LOAD : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (pcnt_q <= 4'd1) state_d = ST_LOAD;
        else                pcnt_d  = pcnt_q - 4'd1;
      end
      ST_LOAD: begin
        if (!eng_busy) begin
          eng_start_d = 1'b1;
          tx_ack_d    = 1'b1;
          eng_tx_d    = sel_tx;
`ifdef SPI_ARB_TIMEOUT_EN
          wd_d        = '0;
`endif
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (eng_done) begin
          rx_data_d  = eng_rx;
          rx_valid_d = 1'b1;
          if (bcnt_q == 4'd0) begin
            pcnt_d  = HOLD_N;
            state_d = ST_HOLD;
          end else begin
            bcnt_d = bcnt_q - 4'd1;
            pcnt_d = GAP_N;
            state_d = (GAP_N == 4'd0) ? ST_LOAD : ST_GAP;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          pcnt_d  = HOLD_N;
          state_d = ST_HOLD;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (pcnt_q <= 4'd1) state_d = ST_LOAD;
        else                pcnt_d  = pcnt_q - 4'd1;
      end
      ST_HOLD: begin
        if (pcnt_q <= 4'd1) begin
          done_d  = 1'b1;
          ss_n_d  = 1'b1;
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else begin
          pcnt_d = pcnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      last_q      <= 1'b1;
      bcnt_q      <= '0;
      pcnt_q      <= '0;
      ss_n_q      <= 1'b1;
      tx_ack_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_tx_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      pcnt_q      <= pcnt_d;
      ss_n_q      <= ss_n_d;
      tx_ack_q    <= tx_ack_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      eng_start_q <= eng_start_d;
      eng_tx_q    <= eng_tx_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign tx_ack    = tx_ack_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign done      = done_q;
  assign eng_start = eng_start_q;
  assign eng_tx    = eng_tx_q;
  assign ss_n      = ss_n_q;

`ifdef SPI_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: behavioural byte engine plus a transfer-level model of
// grants, byte order and frame timing; timeout case runs only with SPI_ARB_TIMEOUT_EN.
module tb_spi_xfer_arbiter;

  localparam int S = 2;
  localparam int H = 2;
  localparam int G = 1;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [7:0] tx_data0, tx_data1;
  logic [1:0] gnt;
  logic       tx_ack, rx_valid, done, err, eng_start, ss_n;
  logic [7:0] rx_data, eng_tx;
  logic       eng_busy, eng_done;
  logic [7:0] eng_rx;

  int unsigned n_cmp;
  int unsigned n_bad;
  int          cyc;
  int          cd;
  int          lat_m;
  bit          eng_mute;
  bit          last_m;
  logic [7:0]  rxq[$];
  logic [7:0]  txb0[16];
  logic [7:0]  txb1[16];
  int          ti0, ti1;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(
    .SETUP_CYC  (S),
    .HOLD_CYC   (H),
    .GAP_CYC    (G),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .tx_data0   (tx_data0),
    .tx_data1   (tx_data1),
    .gnt        (gnt),
    .tx_ack     (tx_ack),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .done       (done),
    .err        (err),
    .eng_start  (eng_start),
    .eng_tx     (eng_tx),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .eng_rx     (eng_rx),
    .ss_n       (ss_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, then act as the byte engine and the requesters.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    eng_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        eng_done = 1'b1;
        eng_rx   = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
      end
    end
    if (eng_start && !eng_mute) cd = lat_m;
    if (tx_ack) begin
      if (gnt[1]) begin
        ti1++;
        tx_data1 = (ti1 < 16) ? txb1[ti1] : 8'h00;
      end else begin
        ti0++;
        tx_data0 = (ti0 < 16) ? txb0[ti0] : 8'h00;
      end
    end
  endtask

  task automatic do_xfer(input logic [1:0] rq, input bit hold, input int lat, input int busy_cyc,
                         input logic [3:0] l0, input logic [3:0] l1, input bit fixed_rx,
                         input string tag);
    int win, n, n0, g_cyc, first_st, exp_first, prev_done, acks, rxs, errs, nst, busy_left;
    int low, exp_low;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] b;
    bit got_gnt, finished;
    got_gnt = 0; finished = 0; acks = 0; rxs = 0; errs = 0; nst = 0; busy_left = 0;
    low = 0; g_cyc = -1; first_st = -1; prev_done = 0;
    len0 = l0;
    len1 = l1;
    for (int i = 0; i < 16; i++) begin
      txb0[i] = 8'($urandom);
      txb1[i] = 8'($urandom);
    end
    ti0 = 0; ti1 = 0;
    tx_data0 = txb0[0];
    tx_data1 = txb1[0];
    if (rq == 2'b11) win = last_m ? 0 : 1;
    else             win = rq[1] ? 1 : 0;
    last_m = (win == 1);
    n = (win == 1) ? int'(l1) + 1 : int'(l0) + 1;
    rxq.delete();
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back((win == 1) ? txb1[k] : txb0[k]);
      b = fixed_rx ? 8'(8'hA1 + k) : 8'($urandom);
      exp_rx.push_back(b);
      rxq.push_back(b);
    end
    lat_m = lat;
    n0 = cyc;
    req = rq;
    exp_first = n0 + 2 + S;
    if (busy_cyc > 0 && n0 + 3 + busy_cyc > exp_first) exp_first = n0 + 3 + busy_cyc;
    exp_low = (exp_first - (n0 + 2)) + n * (lat + 1) + (n - 1) * (G + 1) + H;

    for (int t = 0; t < 1500 && !finished; t++) begin
      step();
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) eng_busy = 1'b0;
      end
      if (!got_gnt && gnt != 2'b00) begin
        got_gnt = 1;
        g_cyc   = cyc;
        check({tag, "_gnt"}, 32'(gnt), (win == 1) ? 32'd2 : 32'd1);
        check({tag, "_ssn_at_gnt"}, 32'(ss_n), 32'd0);
        if (!hold) req = 2'b00;
        if (busy_cyc > 0) begin
          eng_busy  = 1'b1;
          busy_left = busy_cyc;
        end
      end
      if (!ss_n) low++;
      if (eng_done) prev_done = cyc;
      if (eng_start) begin
        if (nst == 0) first_st = cyc;
        else check({tag, "_start_gap"}, 32'(cyc - prev_done), 32'(G + 2));
        check({tag, "_eng_tx"}, 32'(eng_tx), (nst < n) ? 32'(exp_tx[nst]) : 32'hFFFF_FFFF);
        check({tag, "_ack_with_start"}, 32'(tx_ack), 32'd1);
        check({tag, "_gnt_held"}, 32'(gnt), (win == 1) ? 32'd2 : 32'd1);
        nst++;
      end
      if (tx_ack) acks++;
      if (rx_valid) begin
        check({tag, "_rx_data"}, 32'(rx_data), (rxs < n) ? 32'(exp_rx[rxs]) : 32'hFFFF_FFFF);
        check({tag, "_rx_lat"}, 32'(cyc - prev_done), 32'd1);
        rxs++;
      end
      if (err) errs++;
      if (done) begin
        finished = 1;
        check({tag, "_ssn_at_done"}, 32'(ss_n), 32'd1);
        check({tag, "_gnt_at_done"}, 32'(gnt), 32'd0);
      end
    end
    eng_busy = 1'b0;
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_gnt_cycle"}, 32'(g_cyc), 32'(n0 + 2));
    check({tag, "_first_start"}, 32'(first_st), 32'(exp_first));
    check({tag, "_starts"}, 32'(nst), 32'(n));
    check({tag, "_acks"}, 32'(acks), 32'(n));
    check({tag, "_rx_count"}, 32'(rxs), 32'(n));
    check({tag, "_err_count"}, 32'(errs), 32'd0);
    check({tag, "_ssn_low"}, 32'(low), 32'(exp_low));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: observed still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int nst, cnt, lowc, t0, e_cyc, d_cyc, errc, rxs;
    bit gseen;
    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0; tx_data0 = '0; tx_data1 = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_rx = '0;
    cd = 0; lat_m = 8; eng_mute = 0; last_m = 1; cyc = 0; n_cmp = 0; n_bad = 0; ti0 = 0; ti1 = 0;

    step();
    step();
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_eng_tx", 32'(eng_tx), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_ack", 32'(tx_ack), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    rst = 1'b0;
    step();

    // both requesting back to back: grants alternate starting with requester 0
    do_xfer(2'b11, 1, 6, 0, 4'd0, 4'd0, 0, "rr0");
    do_xfer(2'b11, 1, 6, 0, 4'd0, 4'd0, 0, "rr1");
    do_xfer(2'b11, 1, 6, 0, 4'd0, 4'd0, 0, "rr2");
    req = 2'b00;
    step();

    do_xfer(2'b01, 0, 8, 0, 4'd2, 4'd0, 1, "single");
    step();
    do_xfer(2'b01, 0, 8, 5, 4'd1, 4'd0, 0, "busy");
    step();

    // reset in the middle of byte 2
    len0 = 4'd3; lat_m = 8; rxq.delete();
    for (int k = 0; k < 4; k++) rxq.push_back(8'($urandom));
    req = 2'b01; nst = 0;
    for (int t = 0; t < 200 && nst < 2; t++) begin
      step();
      if (gnt != 2'b00) req = 2'b00;
      if (eng_start) nst++;
    end
    check("midrst_reached_byte2", 32'(nst), 32'd2);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("midrst_ss_n", 32'(ss_n), 32'd1);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_eng_tx", 32'(eng_tx), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_tx_ack", 32'(tx_ack), 32'd0);
    check("midrst_eng_start", 32'(eng_start), 32'd0);
    req = 2'b00; cd = 0; rxq.delete(); eng_done = 1'b0;
    last_m = 1;
    step(); step();
    rst = 1'b0;
    cnt = 0; lowc = 0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (done) cnt++;
      if (!ss_n) lowc++;
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    check("midrst_ss_n_stays_high", 32'(lowc), 32'd0);

    // stray eng_done while idle
    eng_done = 1'b1; eng_rx = 8'h5A;
    step();
    check("stray_rx_valid", 32'(rx_valid), 32'd0);
    check("stray_rx_data", 32'(rx_data), 32'd0);
    step();
    check("stray_ss_n", 32'(ss_n), 32'd1);
    check("stray_gnt", 32'(gnt), 32'd0);
    do_xfer(2'b10, 0, 4, 0, 4'd0, 4'd1, 0, "after_stray");
    step();

    for (int r = 0; r < 6; r++) begin
      do_xfer(2'($urandom_range(1, 3)), 0, int'($urandom_range(2, 10)), 0,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, $sformatf("rand%0d", r));
      step();
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // engine never answers: watchdog aborts the transfer
    eng_mute = 1; len0 = 4'd2; req = 2'b01;
    nst = 0; t0 = -1; e_cyc = -1; d_cyc = -1; errc = 0; rxs = 0; gseen = 0;
    for (int t = 0; t < 300 && d_cyc < 0; t++) begin
      step();
      if (!gseen && gnt != 2'b00) begin
        gseen = 1;
        req = 2'b00;
      end
      if (eng_start) begin
        nst++;
        t0 = cyc;
      end
      if (err) begin
        errc++;
        e_cyc = cyc;
      end
      if (rx_valid) rxs++;
      if (done) begin
        d_cyc = cyc;
        check("wd_ss_n_at_done", 32'(ss_n), 32'd1);
      end
    end
    check("wd_err_cycle", 32'(e_cyc), 32'(t0 + T));
    check("wd_done_cycle", 32'(d_cyc), 32'(e_cyc + H));
    check("wd_starts", 32'(nst), 32'd1);
    check("wd_err_count", 32'(errc), 32'd1);
    check("wd_rx_count", 32'(rxs), 32'd0);
    eng_mute = 0;
    last_m = 0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
